core_muldiv_iter: RTL
=====================

# core_muldiv_iter

Iterative, parametrised RISC-V M-extension multiply/divide engine. It replaces the single-cycle combinational multiplier and divider in the execute stage with a one-bit-per-cycle sequential datapath behind valid/ready handshakes. The execute stage issues one request, stalls on `req_ready`/`resp_valid`, and writes `resp_result` back through its write-back path.

## Interface
- `XLEN`, default 32: operand and result width. Must be ≥ 8 and a power of two.
- `clk` input 1: clock, rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `flush` input 1: abort the in-flight operation and drop any pending response.
- `req_valid` input 1: request present.
- `req_ready` output 1: engine can accept a request. High only in IDLE.
- `req_op` input 3: M-extension funct3. 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `req_a` input XLEN: rs1 value (multiplicand/dividend).
- `req_b` input XLEN: rs2 value (multiplier/divisor).
- `resp_valid` output 1: result available.
- `resp_ready` input 1: consumer takes the result.
- `resp_result` output XLEN: result. Stable while `resp_valid` is high.
- `busy` output 1: high in CALC or DONE.

## Operation
- FSM states are IDLE, CALC and DONE. Reset enters IDLE.
- IDLE -> CALC on `req_valid & req_ready & ~flush`.
  - On that edge, capture `req_op`.
  - Capture each operand as its absolute value when it is treated as signed and negative:
    - `req_a` is signed for ops 1, 2, 4, 6.
    - `req_b` is signed for ops 1, 4, 6.
  - Capture the result-sign flags:
    - mul: sign(a) XOR sign(b).
    - quotient: sign(a) XOR sign(b).
    - remainder: sign(a).
  - Clear the iteration counter (width clog2(XLEN)+1).
- CALC, multiply: shift-add into a 2·XLEN product register, one multiplier bit per cycle, LSB first.
- CALC, divide: restoring division on magnitudes, one quotient bit per cycle, MSB first. The XLEN+1-bit trial subtract sets the quotient bit when the difference is non-negative.
- CALC -> DONE after exactly XLEN iterations.
- DONE, sign fix: negate the product, quotient or remainder (two's complement) when its sign flag is set.
- DONE, result selection:
  - MUL: low XLEN bits of the product.
  - MULH, MULHSU, MULHU: high XLEN bits of the signed-corrected product.
- Divide by zero:
  - DIV/DIVU return all ones.
  - REM/REMU return the original `req_a`, held in a captured copy.
  - Both results bypass sign fix.
- Signed overflow (DIV of -2^(XLEN-1) by -1) falls out naturally:
  - Quotient is 2^(XLEN-1), which is 0x8000_0000 for XLEN=32.
  - Remainder is 0.
- DONE -> IDLE on `resp_valid & resp_ready`. A new request is not accepted in that same cycle.
- `flush` in any state forces IDLE on the next edge. It has priority over request acceptance and the response handshake, and the response is lost.

## Timing
- Reset values: state IDLE, `req_ready`=1, `resp_valid`=0, `busy`=0, `resp_result`=0. All datapath registers are cleared to 0.
- Latency: with acceptance at edge E0, `resp_valid` goes high in the cycle after edge E0+XLEN, independent of operand values. For XLEN=32 that is 32 cycles.
- Throughput: one operation per XLEN+2 cycles minimum (accept, XLEN iterations, response cycle).
- `resp_result` is driven from registers plus the sign-fix negate. It holds constant through any number of `resp_ready`=0 cycles.
- `rst_n` asserted mid-operation returns the engine to reset values immediately, without waiting for a clock edge.

## Configuration
- `CORE_MULDIV_FASTPATH_EN`:
  - Defined: divide-by-zero requests and any request with `req_b`==0 for ops 4–7 go IDLE -> DONE on the accept edge. `resp_valid` is then high in the next cycle (latency 1).
  - Undefined: these requests take the full XLEN cycles.
  - Results are identical in both builds.

## Test plan
- MUL with XLEN=32, a=7, b=-3: `resp_result`=0xFFFF_FFEB. MULH of the same operands gives 0xFFFF_FFFF. `resp_valid` rises exactly 32 cycles after acceptance.
- MULHU a=0xFFFF_FFFF, b=0xFFFF_FFFF -> 0xFFFF_FFFE. MULHSU a=-1, b=0xFFFF_FFFF -> 0xFFFF_FFFF.
- DIV a=-7, b=2 -> 0xFFFF_FFFD. REM of the same -> 0xFFFF_FFFF. DIV a=0x8000_0000, b=-1 -> 0x8000_0000. REM of the same -> 0.
- DIVU a=5, b=0 -> 0xFFFF_FFFF. REMU a=5, b=0 -> 5. Latency is 1 with `CORE_MULDIV_FASTPATH_EN` defined and 32 without it.
- Backpressure: hold `resp_ready`=0 for 10 cycles in DONE. `resp_result` must stay stable and `req_ready` must stay 0. The handshake then returns the engine to IDLE with `req_ready`=1 in the next cycle.
- Abort and reset:
  - `flush` at iteration 10: no `resp_valid`, IDLE on the next edge. A following MUL 3×4 -> 12.
  - `rst_n` low mid-CALC: all outputs take reset values immediately.

Source files
------------

// File: rtl/core_muldiv_iter.sv
// Iterative RISC-V M-extension multiply/divide engine, one bit per cycle.
// Optional CORE_MULDIV_FASTPATH_EN: divide by zero completes on the accept edge.
module core_muldiv_iter #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_result,
  output logic            busy
);

  localparam int unsigned CntW = $clog2(XLEN) + 1;
  localparam logic [CntW-1:0] LastIter = CntW'(XLEN - 1);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e state_q, state_d;

  logic [2:0]        op_q;
  logic [XLEN-1:0]   a_orig_q;
  logic [XLEN-1:0]   opd_q;
  logic [2*XLEN-1:0] acc_q;
  logic [CntW-1:0]   cnt_q;
  logic              bz_q;
  logic              neg_prod_q;
  logic              neg_rem_q;

  logic            accept;
  logic            is_div_req;
  logic            a_signed;
  logic            b_signed;
  logic            sign_a;
  logic            sign_b;
  logic [XLEN-1:0] abs_a;
  logic [XLEN-1:0] abs_b;
  logic            b_zero;
  logic            fast;

  assign req_ready  = (state_q == StIdle);
  assign resp_valid = (state_q == StDone);
  assign busy       = (state_q != StIdle);
  assign accept     = req_valid & req_ready & ~flush;

  assign is_div_req = req_op[2];
  assign a_signed   = (req_op == 3'd1) || (req_op == 3'd2) || (req_op == 3'd4) ||
                      (req_op == 3'd6);
  assign b_signed   = (req_op == 3'd1) || (req_op == 3'd4) || (req_op == 3'd6);
  assign sign_a     = a_signed & req_a[XLEN-1];
  assign sign_b     = b_signed & req_b[XLEN-1];
  assign abs_a      = sign_a ? (~req_a + 1'b1) : req_a;
  assign abs_b      = sign_b ? (~req_b + 1'b1) : req_b;
  assign b_zero     = (req_b == '0);

`ifdef CORE_MULDIV_FASTPATH_EN
  assign fast = is_div_req & b_zero;
`else
  assign fast = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept) state_d = fast ? StDone : StCalc;
      StCalc: if (cnt_q == LastIter) state_d = StDone;
      StDone: if (resp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (flush) state_d = StIdle;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Multiply: acc = {partial sum, remaining multiplier bits}, shifted right each step.
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opd_q} : '0);
  assign mul_next = {mul_sum, acc_q[XLEN-1:1]};

  // Divide: acc = {partial remainder, dividend/quotient}, shifted left each step.
  logic [XLEN:0]     div_trial;
  logic [XLEN:0]     div_diff;
  logic [2*XLEN-1:0] div_next;
  assign div_trial = acc_q[2*XLEN-1:XLEN-1];
  assign div_diff  = div_trial - {1'b0, opd_q};
  assign div_next  = div_diff[XLEN] ? {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                    : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q       <= '0;
      a_orig_q   <= '0;
      opd_q      <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      bz_q       <= 1'b0;
      neg_prod_q <= 1'b0;
      neg_rem_q  <= 1'b0;
    end else if (accept) begin
      op_q       <= req_op;
      a_orig_q   <= req_a;
      opd_q      <= is_div_req ? abs_b : abs_a;
      acc_q      <= {{XLEN{1'b0}}, (is_div_req ? abs_a : abs_b)};
      cnt_q      <= '0;
      bz_q       <= b_zero;
      neg_prod_q <= sign_a ^ sign_b;
      neg_rem_q  <= sign_a;
    end else if (state_q == StCalc) begin
      cnt_q <= cnt_q + 1'b1;
      acc_q <= op_q[2] ? div_next : mul_next;
    end
  end

  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix;
  logic [XLEN-1:0]   rem_fix;
  logic [XLEN-1:0]   result;

  assign prod_fix = neg_prod_q ? (~acc_q + 1'b1) : acc_q;
  assign quo_fix  = neg_prod_q ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0];
  assign rem_fix  = neg_rem_q ? (~acc_q[2*XLEN-1:XLEN] + 1'b1) : acc_q[2*XLEN-1:XLEN];

  always_comb begin
    result = '0;
    case (op_q)
      3'd0:                result = prod_fix[XLEN-1:0];
      3'd1, 3'd2, 3'd3:    result = prod_fix[2*XLEN-1:XLEN];
      3'd4, 3'd5:          result = bz_q ? {XLEN{1'b1}} : quo_fix;
      default:             result = bz_q ? a_orig_q : rem_fix;
    endcase
  end

  assign resp_result = resp_valid ? result : '0;

endmodule
